// File: rtl/state_dumper_pkg.sv
// Shared definitions for the state dumper: FSM encoding, record-source
// encodings and the packed output record layout.
package state_dumper_pkg;

   // Dump sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GPR  = 2'd1,
      ST_DM   = 2'd2,
      ST_FIN  = 2'd3
   } dump_state_t;

   // Record source encodings presented on out_sel
   localparam logic SEL_GPR = 1'b0;
   localparam logic SEL_DM  = 1'b1;

   // Field widths
   localparam int GPR_AW = 5;
   localparam int DM_AW  = 10;
   localparam int IDX_W  = 10;
   localparam int DATA_W = 32;
   localparam int REC_W  = 1 + IDX_W + DATA_W;

   // One output record: source, index and captured value (43 bits)
   typedef struct packed {
      logic              sel;
      logic [IDX_W-1:0]  index;
      logic [DATA_W-1:0] data;
   } dump_rec_t;

   // Index of the record following idx within the same source
   function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] idx);
      return idx + 10'd1;
   endfunction

endpackage

// File: rtl/state_dumper.sv
// State dumper: on a start request, streams the first NUM_GPR register-file
// entries followed by the first NUM_DM data-memory words as valid/ready
// records. The record register is loaded on the same edge that the previous
// record transfers, so a consumer holding out_ready high gets one record per
// cycle with no bubble at the register-file / data-memory boundary.
module state_dumper
   import state_dumper_pkg::*;
#(
   parameter int NUM_GPR = 10,
   parameter int NUM_DM  = 10
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   output logic [GPR_AW-1:0] gpr_raddr,
   input  logic [DATA_W-1:0] gpr_rdata,
   output logic [DM_AW-1:0]  dm_raddr,
   input  logic [DATA_W-1:0] dm_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_sel,
   output logic [IDX_W-1:0]  out_index,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              done
);

   // Index of the final record of each phase
   localparam logic [IDX_W-1:0] GPR_LAST = IDX_W'(NUM_GPR - 1);
   localparam logic [IDX_W-1:0] DM_LAST  = IDX_W'(NUM_DM - 1);

   dump_state_t      r_state;
   dump_state_t      w_state_next;
   dump_rec_t        r_rec;
   dump_rec_t        w_rec_next;
   logic             r_valid;
   logic             w_valid_next;

   logic             w_xfer;
   logic             w_gpr_last;
   logic             w_dm_last;
   logic [IDX_W-1:0] w_index_inc;

   // A record leaves only when it is actually presented and accepted;
   // out_ready alone has no effect.
   assign w_xfer      = r_valid & out_ready;
   assign w_gpr_last  = (r_rec.index == GPR_LAST);
   assign w_dm_last   = (r_rec.index == DM_LAST);
   assign w_index_inc = next_index(r_rec.index);

   assign out_valid = r_valid;
   assign out_sel   = r_rec.sel;
   assign out_index = r_rec.index;
   assign out_data  = r_rec.data;

   // State register; reset overrides everything, including a running dump
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic: phases advance only on transfer of their last record
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_next = ST_GPR;
            end
         end
         ST_GPR: begin
            if (w_xfer && w_gpr_last) begin
               w_state_next = ST_DM;
            end
         end
         ST_DM: begin
            if (w_xfer && w_dm_last) begin
               w_state_next = ST_FIN;
            end
         end
         ST_FIN: begin
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Next record: loaded on start or on a transfer, otherwise held so a
   // stalled record stays stable and is never re-read.
   always_comb begin
      w_rec_next   = r_rec;
      w_valid_next = r_valid;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_valid_next     = 1'b1;
               w_rec_next.sel   = SEL_GPR;
               w_rec_next.index = '0;
               w_rec_next.data  = gpr_rdata;
            end
         end
         ST_GPR: begin
            if (w_xfer) begin
               w_valid_next = 1'b1;
               if (w_gpr_last) begin
                  // Hand over straight to data-memory word 0
                  w_rec_next.sel   = SEL_DM;
                  w_rec_next.index = '0;
                  w_rec_next.data  = dm_rdata;
               end else begin
                  w_rec_next.sel   = SEL_GPR;
                  w_rec_next.index = w_index_inc;
                  w_rec_next.data  = gpr_rdata;
               end
            end
         end
         ST_DM: begin
            if (w_xfer) begin
               if (w_dm_last) begin
                  w_valid_next = 1'b0;
               end else begin
                  w_valid_next     = 1'b1;
                  w_rec_next.sel   = SEL_DM;
                  w_rec_next.index = w_index_inc;
                  w_rec_next.data  = dm_rdata;
               end
            end
         end
         ST_FIN: begin
            w_valid_next = 1'b0;
         end
         default: begin
            w_valid_next = 1'b0;
         end
      endcase
   end

   // Output record holding register; reset discards any pending record
   always_ff @(posedge clock) begin
      if (reset) begin
         r_rec   <= '0;
         r_valid <= 1'b0;
      end else begin
         r_rec   <= w_rec_next;
         r_valid <= w_valid_next;
      end
   end

   // Status flags and read addresses. Each address points at the record
   // that would be loaded next; the address of the inactive source is 0.
   always_comb begin
      busy      = 1'b0;
      done      = 1'b0;
      gpr_raddr = '0;
      dm_raddr  = '0;
      case (r_state)
         ST_IDLE: begin
            // Next load on start is register 0, already addressed by 0
            gpr_raddr = '0;
         end
         ST_GPR: begin
            busy = 1'b1;
            if (!w_gpr_last) begin
               gpr_raddr = w_index_inc[GPR_AW-1:0];
            end
            // On the last register, dm_raddr = 0 addresses word 0
         end
         ST_DM: begin
            busy = 1'b1;
            if (!w_dm_last) begin
               dm_raddr = w_index_inc;
            end
         end
         ST_FIN: begin
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_state_dumper.sv
// Bench for state_dumper: a scoreboard queue is filled by the stimulus and
// drained by a negedge monitor on every accepted record. A second instance
// with one register and one memory word is checked directly.
module tb_state_dumper;

   typedef struct packed {
      logic        sel;
      logic [9:0]  idx;
      logic [31:0] data;
   } rec_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        out_ready;
   logic [4:0]  gpr_raddr;
   logic [31:0] gpr_rdata;
   logic [9:0]  dm_raddr;
   logic [31:0] dm_rdata;
   logic        out_valid;
   logic        out_sel;
   logic [9:0]  out_index;
   logic [31:0] out_data;
   logic        busy;
   logic        done;

   logic        s_start;
   logic        s_ready;
   logic [4:0]  s_gpr_raddr;
   logic [31:0] s_gpr_rdata;
   logic [9:0]  s_dm_raddr;
   logic [31:0] s_dm_rdata;
   logic        s_valid;
   logic        s_sel;
   logic [9:0]  s_index;
   logic [31:0] s_data;
   logic        s_busy;
   logic        s_done;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_xfer   = 0;
   int   n_done   = 0;
   int   cyc      = 0;
   int   first_cyc = -1;
   int   last_cyc  = -1;
   rec_t exp_q[$];
   rec_t held;
   logic stall_pending = 1'b0;
   logic final_pending = 1'b0;

   // Combinational memory models: register i = 0x1000+i, word i = 0xA000+i
   assign gpr_rdata   = 32'h1000 + {27'd0, gpr_raddr};
   assign dm_rdata    = 32'hA000 + {22'd0, dm_raddr};
   assign s_gpr_rdata = 32'h1000 + {27'd0, s_gpr_raddr};
   assign s_dm_rdata  = 32'hA000 + {22'd0, s_dm_raddr};

   state_dumper #(.NUM_GPR(10), .NUM_DM(10)) dut (
      .clock(clock), .reset(reset), .start(start),
      .gpr_raddr(gpr_raddr), .gpr_rdata(gpr_rdata),
      .dm_raddr(dm_raddr), .dm_rdata(dm_rdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sel(out_sel), .out_index(out_index), .out_data(out_data),
      .busy(busy), .done(done)
   );

   state_dumper #(.NUM_GPR(1), .NUM_DM(1)) dut_small (
      .clock(clock), .reset(reset), .start(s_start),
      .gpr_raddr(s_gpr_raddr), .gpr_rdata(s_gpr_rdata),
      .dm_raddr(s_dm_raddr), .dm_rdata(s_dm_rdata),
      .out_valid(s_valid), .out_ready(s_ready),
      .out_sel(s_sel), .out_index(s_index), .out_data(s_data),
      .busy(s_busy), .done(s_done)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compares every accepted record against the scoreboard head
   always @(negedge clock) begin
      rec_t e;
      if (reset) begin
         stall_pending = 1'b0;
         final_pending = 1'b0;
      end else begin
         chk("done_timing", 64'(done), 64'(final_pending));
         chk("busy_vs_valid", 64'(busy), 64'(out_valid));
         if (done) n_done++;
         final_pending = 1'b0;
         if (stall_pending && out_valid) begin
            chk("stall_sel", 64'(out_sel), 64'(held.sel));
            chk("stall_index", 64'(out_index), 64'(held.idx));
            chk("stall_data", 64'(out_data), 64'(held.data));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_record: got sel=%0d idx=%0d data=0x%0h, expected none",
                        out_sel, out_index, out_data);
            end else begin
               e = exp_q.pop_front();
               chk("rec_sel", 64'(out_sel), 64'(e.sel));
               chk("rec_index", 64'(out_index), 64'(e.idx));
               chk("rec_data", 64'(out_data), 64'(e.data));
               final_pending = e.sel && (e.idx == 10'd9);
            end
            $display("xfer cyc=%0d sel=%0d idx=%0d data=0x%08h", cyc, out_sel, out_index, out_data);
            n_xfer++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
         end
         stall_pending = out_valid && !out_ready;
         held = '{sel: out_sel, idx: out_index, data: out_data};
      end
   end

   task automatic push_dump();
      for (int i = 0; i < 10; i++) exp_q.push_back('{sel: 1'b0, idx: 10'(i), data: 32'h1000 + 32'(i)});
      for (int i = 0; i < 10; i++) exp_q.push_back('{sel: 1'b1, idx: 10'(i), data: 32'hA000 + 32'(i)});
   endtask

   task automatic pulse_start();
      @(posedge clock); #1 start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
   endtask

   task automatic wait_done(input int target, input int bound);
      int k = 0;
      while (n_done < target && k < bound) begin
         @(posedge clock);
         k++;
      end
      #1;
      if (n_done < target) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_timeout: got %0d done pulses, expected %0d", n_done, target);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_sel"}, 64'(out_sel), 64'd0);
      chk({tag, "_index"}, 64'(out_index), 64'd0);
      chk({tag, "_data"}, 64'(out_data), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_gpr_raddr"}, 64'(gpr_raddr), 64'd0);
      chk({tag, "_dm_raddr"}, 64'(dm_raddr), 64'd0);
   endtask

   initial begin
      int d0;
      int x0;
      int k;
      logic restarted;
      reset = 1'b1; start = 1'b0; out_ready = 1'b0; s_start = 1'b0; s_ready = 1'b0;

      // Reset state
      repeat (3) @(posedge clock);
      #1 chk_reset_outputs("reset");
      reset = 1'b0;

      // Full throughput dump
      out_ready = 1'b1; first_cyc = -1; d0 = n_done; x0 = n_xfer;
      push_dump();
      pulse_start();
      chk("start_latency_valid", 64'(out_valid), 64'd1);
      chk("start_next_raddr", 64'(gpr_raddr), 64'd1);
      wait_done(d0 + 1, 60);
      chk("full_xfer_count", 64'(n_xfer - x0), 64'd20);
      chk("full_span", 64'(last_cyc - first_cyc), 64'd19);
      chk("full_queue_empty", 64'(exp_q.size()), 64'd0);
      repeat (3) @(posedge clock);
      chk("full_done_count", 64'(n_done - d0), 64'd1);

      // Ready toggling every cycle
      d0 = n_done; x0 = n_xfer;
      push_dump();
      pulse_start();
      k = 0;
      while (n_done < d0 + 1 && k < 100) begin
         @(posedge clock); #1 out_ready = ~out_ready;
         k++;
      end
      out_ready = 1'b1;
      chk("toggle_finished", 64'(n_done - d0), 64'd1);
      chk("toggle_xfer_count", 64'(n_xfer - x0), 64'd20);
      chk("toggle_queue_empty", 64'(exp_q.size()), 64'd0);

      // Second start pulse while dumping GPR record 5
      d0 = n_done; x0 = n_xfer; restarted = 1'b0;
      push_dump();
      pulse_start();
      k = 0;
      while (n_done < d0 + 1 && k < 60) begin
         @(posedge clock); #1;
         if (!restarted && out_valid && !out_sel && out_index == 10'd5) begin
            start = 1'b1; restarted = 1'b1;
         end else begin
            start = 1'b0;
         end
         k++;
      end
      start = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      chk("restart_seen", 64'(restarted), 64'd1);
      chk("restart_xfer_count", 64'(n_xfer - x0), 64'd20);
      chk("restart_done_count", 64'(n_done - d0), 64'd1);
      chk("restart_idle_busy", 64'(busy), 64'd0);

      // Reset while GPR record 3 is presented and stalled
      x0 = n_xfer;
      push_dump();
      pulse_start();
      k = 0;
      while (k < 20 && !(out_valid && !out_sel && out_index == 10'd3)) begin
         @(posedge clock); #1;
         k++;
      end
      chk("reset_reached_rec3", 64'(out_index), 64'd3);
      out_ready = 1'b0; reset = 1'b1;
      @(posedge clock); #1;
      chk_reset_outputs("midreset");
      chk("midreset_xfer_count", 64'(n_xfer - x0), 64'd3);
      exp_q.delete();
      reset = 1'b0; out_ready = 1'b1;
      d0 = n_done; x0 = n_xfer;
      push_dump();
      pulse_start();
      wait_done(d0 + 1, 60);
      chk("after_reset_xfer_count", 64'(n_xfer - x0), 64'd20);

      // Long stall on the final data-memory record
      d0 = n_done; x0 = n_xfer;
      push_dump();
      pulse_start();
      k = 0;
      while (k < 40 && !(out_valid && out_sel && out_index == 10'd9)) begin
         @(posedge clock); #1;
         k++;
      end
      out_ready = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clock); #1;
         chk("longstall_valid", 64'(out_valid), 64'd1);
         chk("longstall_done", 64'(done), 64'd0);
      end
      out_ready = 1'b1;
      wait_done(d0 + 1, 10);
      repeat (3) @(posedge clock);
      chk("longstall_xfer_count", 64'(n_xfer - x0), 64'd20);
      chk("longstall_done_count", 64'(n_done - d0), 64'd1);

      // Single-entry instance: GPR 0 then DM 0 back to back
      s_ready = 1'b1;
      @(posedge clock); #1 s_start = 1'b1;
      @(posedge clock); #1 s_start = 1'b0;
      chk("small_r0_valid", 64'(s_valid), 64'd1);
      chk("small_r0_sel", 64'(s_sel), 64'd0);
      chk("small_r0_index", 64'(s_index), 64'd0);
      chk("small_r0_data", 64'(s_data), 64'h1000);
      chk("small_r0_busy", 64'(s_busy), 64'd1);
      @(posedge clock); #1;
      $display("xfer small sel=0 idx=0 data=0x00001000");
      chk("small_r1_valid", 64'(s_valid), 64'd1);
      chk("small_r1_sel", 64'(s_sel), 64'd1);
      chk("small_r1_index", 64'(s_index), 64'd0);
      chk("small_r1_data", 64'(s_data), 64'hA000);
      chk("small_r1_busy", 64'(s_busy), 64'd1);
      @(posedge clock); #1;
      $display("xfer small sel=1 idx=0 data=0x0000a000");
      chk("small_fin_valid", 64'(s_valid), 64'd0);
      chk("small_fin_done", 64'(s_done), 64'd1);
      chk("small_fin_busy", 64'(s_busy), 64'd0);
      @(posedge clock); #1;
      chk("small_idle_done", 64'(s_done), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/state_dumper.md
STATE_DUMPER -- requirements
Module: state_dumper

Interface
REQ-001 Parameter NUM_GPR, default 10, number of register-file entries dumped (1..32), starting at register 0.
REQ-002 Parameter NUM_DM, default 10, number of data-memory words dumped (1..1024), starting at word 0.
REQ-003 clock  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a dump.
REQ-006 gpr_raddr  output  5  register-file read address; register file read is combinational.
REQ-007 gpr_rdata  input  32  register-file read data for gpr_raddr, same cycle.
REQ-008 dm_raddr  output  10  data-memory word address; memory read is combinational.
REQ-009 dm_rdata  input  32  data-memory read data for dm_raddr, same cycle.
REQ-010 out_valid  output  1  out_sel/out_index/out_data hold a valid record.
REQ-011 out_ready  input  1  consumer accepts the record when high with out_valid.
REQ-012 out_sel  output  1  record source: 0 = register file, 1 = data memory.
REQ-013 out_index  output  10  register number or word index of the record.
REQ-014 out_data  output  32  captured value.
REQ-015 busy  output  1  high from the cycle after start is accepted until done.
REQ-016 done  output  1  one-cycle pulse after the final record transfers.

Function
REQ-017 FSM states IDLE, GPR, DM, FIN; IDLE->GPR on start; GPR->DM after record NUM_GPR-1 transfers; DM->FIN after record NUM_DM-1 transfers; FIN->IDLE unconditionally.
REQ-018 start SHALL be ignored in any state other than IDLE.
REQ-019 Start accepted at edge N: at edge N+1 out_valid=1, out_sel=0, out_index=0, out_data=register 0.
REQ-020 A transfer occurs on an edge where out_valid && out_ready; the next record SHALL be loaded on that same edge (one record per cycle at full throughput).
REQ-021 While out_valid && !out_ready, out_sel, out_index and out_data SHALL hold stable; no re-read occurs.
REQ-022 gpr_raddr/dm_raddr SHALL present the address of the next record to be loaded; data is captured from gpr_rdata/dm_rdata at the loading edge.
REQ-023 Transfer of GPR record NUM_GPR-1 SHALL load DM record 0 (out_sel=1, out_index=0) on the same edge, with no bubble.
REQ-024 Transfer of DM record NUM_DM-1 SHALL clear out_valid and enter FIN; done=1 for exactly the FIN cycle; busy=0 in FIN and IDLE.
REQ-025 Index counters SHALL never exceed NUM_GPR-1 / NUM_DM-1; no wrap-around occurs within one dump.
REQ-026 out_ready while out_valid=0 SHALL have no effect.
REQ-027 Unused address outputs SHALL be driven to 0 outside their phase.

Reset
REQ-028 reset SHALL win over all other inputs, including start and an in-progress dump, and SHALL force IDLE on the next edge.
REQ-029 After reset: out_valid=0, out_sel=0, out_index=0, out_data=0, busy=0, done=0, gpr_raddr=0, dm_raddr=0.
REQ-030 A record pending at reset SHALL be discarded, not re-presented.

Structure
REQ-031 FSM state encoding and the out_sel encodings (SEL_GPR=0, SEL_DM=1) SHALL reside in the shared CPU package.
REQ-032 The design SHALL be one module with no sub-modules; the output record register is a single 43-bit holding register.

Verification
REQ-033 With default parameters, registers i = 0x1000+i and DM words i = 0xA000+i, start pulse, out_ready=1 -> 20 records in consecutive cycles: GPR 0..9 then DM 0..9 with matching data; done pulses one cycle after the last record.
REQ-034 Same setup, out_ready toggled 1/0 each cycle -> the same 20 records in the same order; each record stable while stalled; no duplicate or missing record.
REQ-035 start pulses again during the dump at record 5 -> ignored; exactly 20 records; single done pulse.
REQ-036 reset asserted while out_valid=1 on GPR record 3 -> next cycle all outputs are at reset values; a new start gives GPR record 0 first.
REQ-037 NUM_GPR=1, NUM_DM=1 -> exactly two records (GPR 0, DM 0) back-to-back; done pulses on the following cycle; busy spans the records.
REQ-038 out_ready held 0 for 50 cycles on DM record 9 -> out_valid held, done stays 0 until the transfer, then pulses once.
